// File: rtl/muldiv_unit_if.sv
// Request/write-back bundle between the issue logic, the muldiv_unit and the
// register file write port.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1Data;
  logic [XLEN-1:0] rs2Data;
  logic [4:0]      rdAdrsIn;
  logic            busy;
  logic            enable;
  logic [4:0]      rdAdrs;
  logic [XLEN-1:0] rdData;

  modport master (
    output start, funct3, rs1Data, rs2Data, rdAdrsIn,
    input  busy, enable, rdAdrs, rdData
  );

  modport slave (
    input  start, funct3, rs1Data, rs2Data, rdAdrsIn,
    output busy, enable, rdAdrs, rdData
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, sign fix-up and special-case override at the end.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic         clock,
  input logic         resetN,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [2*XLEN-1:0] work_q, work_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              div_zero_q, div_zero_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              enable_q, enable_d;
  logic [4:0]        rd_adrs_q, rd_adrs_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;

  logic              is_div_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_abs_s, b_abs_s;
  logic              ovf_s, div_zero_s;
  logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, a_raw_s, result_s;

  // Decode operand signedness and magnitudes from the incoming request.
  always_comb begin
    is_div_s   = bus.funct3[2];
    a_signed_s = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
    b_signed_s = a_signed_s && (bus.funct3 != 3'b010);
    a_neg_s    = a_signed_s && bus.rs1Data[XLEN-1];
    b_neg_s    = b_signed_s && bus.rs2Data[XLEN-1];
    a_abs_s    = a_neg_s ? ({XLEN{1'b0}} - bus.rs1Data) : bus.rs1Data;
    b_abs_s    = b_neg_s ? ({XLEN{1'b0}} - bus.rs2Data) : bus.rs2Data;
    div_zero_s = is_div_s && (bus.rs2Data == {XLEN{1'b0}});
    ovf_s      = is_div_s && b_signed_s
                 && (bus.rs1Data == {1'b1, {(XLEN-1){1'b0}}})
                 && (bus.rs2Data == {XLEN{1'b1}});
  end

  // Single iteration datapath; work_q holds {hi, lo} = {product hi, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum_s   = {1'b0, work_q[2*XLEN-1:XLEN]}
                  + (work_q[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
    div_shift_s = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, b_mag_q};
  end

  // Sign fix-up and special-case selection of the final result.
  always_comb begin
    prod_s  = neg_q ? ({(2*XLEN){1'b0}} - work_q) : work_q;
    quo_s   = neg_q ? ({XLEN{1'b0}} - work_q[XLEN-1:0]) : work_q[XLEN-1:0];
    rem_s   = rem_neg_q ? ({XLEN{1'b0}} - work_q[2*XLEN-1:XLEN]) : work_q[2*XLEN-1:XLEN];
    a_raw_s = rem_neg_q ? ({XLEN{1'b0}} - a_mag_q) : a_mag_q;
    case (op_q)
      3'b000:                 result_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div_zero_q) begin
          result_s = {XLEN{1'b1}};
        end else if (ovf_q) begin
          result_s = a_raw_s;
        end else begin
          result_s = quo_s;
        end
      end
      3'b110, 3'b111: begin
        if (div_zero_q) begin
          result_s = a_raw_s;
        end else if (ovf_q) begin
          result_s = {XLEN{1'b0}};
        end else begin
          result_s = rem_s;
        end
      end
      default:                result_s = {XLEN{1'b0}};
    endcase
  end

  // FSM next-state, operand capture and write-back register update.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    rd_d       = rd_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    work_d     = work_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    busy_d     = (state_q != IDLE);
    enable_d   = 1'b0;
    rd_adrs_d  = rd_adrs_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = CALC;
          count_d    = {CW{1'b0}};
          op_d       = bus.funct3;
          rd_d       = bus.rdAdrsIn;
          a_mag_d    = a_abs_s;
          b_mag_d    = b_abs_s;
          work_d     = {{XLEN{1'b0}}, (is_div_s ? a_abs_s : b_abs_s)};
          neg_d      = a_neg_s ^ b_neg_s;
          rem_neg_d  = a_neg_s;
          div_zero_d = div_zero_s;
          ovf_d      = ovf_s;
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      CALC: begin
        count_d = count_q + CW'(1);
        if (op_q[2]) begin
          // Restoring step: keep the shifted remainder when the trial subtract underflows.
          if (div_diff_s[XLEN]) begin
            work_d = {div_shift_s[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
          end else begin
            work_d = {div_diff_s[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
          end
        end else begin
          work_d = {mul_sum_s, work_q[XLEN-1:1]};
        end
        if (count_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        state_d   = IDLE;
        enable_d  = (rd_q != 5'd0);
        rd_adrs_d = rd_q;
        rd_data_d = result_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      count_q    <= {CW{1'b0}};
      op_q       <= 3'b000;
      rd_q       <= 5'd0;
      a_mag_q    <= {XLEN{1'b0}};
      b_mag_q    <= {XLEN{1'b0}};
      work_q     <= {(2*XLEN){1'b0}};
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      enable_q   <= 1'b0;
      rd_adrs_q  <= 5'd0;
      rd_data_q  <= {XLEN{1'b0}};
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      work_q     <= work_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      enable_q   <= enable_d;
      rd_adrs_q  <= rd_adrs_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.enable = enable_q;
  assign bus.rdAdrs = rd_adrs_q;
  assign bus.rdData = rd_data_q;
endmodule
